// File: rtl/m_cycle_sequencer_pkg.sv
// cpu_seq_pkg: sequencer state encoding, special opcodes and the M-cycle count lookup.
// Both table functions return the final M-cycle index of an instruction, which is its M-cycle count minus one.
// m_cycle_num_prefix returns the index for the CB suffix alone; the CB prefix byte's own cycle is not included.
package cpu_seq_pkg;
  typedef enum logic [1:0] {S_EXEC, S_CB, S_HALT} seq_state_t;
  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_HALT   = 8'h76;
  localparam logic [7:0] OP_PREFIX = 8'hCB;
  function automatic logic [2:0] m_cycle_num(input logic [7:0] o);
    logic [2:0] r;
    r = 3'd0;
    case (o[7:6])
      2'b00: case (o[2:0])
        3'd0: r = o[5:3] == 3'd1 ? 3'd4 : (o[5:3] == 3'd0 || o[5:3] == 3'd2) ? 3'd0 : 3'd2;
        3'd1: r = o[3] ? 3'd1 : 3'd2;
        3'd2, 3'd3: r = 3'd1;
        3'd4, 3'd5: r = o[5:3] == 3'd6 ? 3'd2 : 3'd0;
        3'd6: r = o[5:3] == 3'd6 ? 3'd2 : 3'd1;
        default: r = 3'd0;
      endcase
      2'b01: r = (o != OP_HALT && (o[2:0] == 3'd6 || o[5:3] == 3'd6)) ? 3'd1 : 3'd0;
      2'b10: r = o[2:0] == 3'd6 ? 3'd1 : 3'd0;
      default: case (o)
        8'hC4, 8'hCC, 8'hD4, 8'hDC, 8'hCD: r = 3'd5;
        8'hC0, 8'hC8, 8'hD0, 8'hD8: r = 3'd4;
        8'hC2, 8'hC3, 8'hC5, 8'hC7, 8'hC9, 8'hCA, 8'hCF, 8'hD2, 8'hD5, 8'hD7, 8'hD9,
        8'hDA, 8'hDF, 8'hE5, 8'hE7, 8'hE8, 8'hEA, 8'hEF, 8'hF5, 8'hF7, 8'hFA, 8'hFF: r = 3'd3;
        8'hC1, 8'hD1, 8'hE0, 8'hE1, 8'hF0, 8'hF1, 8'hF8: r = 3'd2;
        8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE2, 8'hE6, 8'hEE, 8'hF2, 8'hF6, 8'hF9, 8'hFE: r = 3'd1;
        8'hCB, 8'hE9, 8'hF3, 8'hFB: r = 3'd0;
        default: r = 3'bxxx;
      endcase
    endcase
    return r;
  endfunction
  function automatic logic [2:0] m_cycle_num_prefix(input logic [7:0] o);
    return o[2:0] != 3'd6 ? 3'd0 : o[7:6] == 2'b01 ? 3'd1 : 3'd2;
  endfunction
endpackage

// File: rtl/m_cycle_sequencer_table.sv
// m_cycle_num_table: per-opcode final M-cycle index lookup.
// Ports: op / op_prefix are the main and CB-suffix opcodes; last_main / last_cb are their final indices.
module m_cycle_num_table
  import cpu_seq_pkg::*;
(
  input  logic [7:0] op,
  input  logic [7:0] op_prefix,
  output logic [2:0] last_main,
  output logic [2:0] last_cb
);
  always_comb begin
    last_main = m_cycle_num(op);
    last_cb = m_cycle_num_prefix(op_prefix);
  end
endmodule

// File: rtl/m_cycle_sequencer.sv
// m_cycle_sequencer: steps the M-cycle index of the current opcode and handles fetch, CB prefix, HALT and early exit.
// Ports: clk/n_reset clock and async active-low reset; tick marks an M-cycle boundary; rdata is the fetched byte;
// cut_short ends a conditional instruction early; irq_pending wakes HALT; op/op_prefix/is_prefix/m_cycle/halted
// report sequencer state; final_cycle flags the last M-cycle; instr_done pulses one clk after an instruction ends.
module m_cycle_sequencer
  import cpu_seq_pkg::*;
#(
  parameter logic [7:0] RESET_OP = 8'h00
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       tick,
  input  logic [7:0] rdata,
  input  logic       cut_short,
  input  logic       irq_pending,
  output logic [7:0] op,
  output logic [7:0] op_prefix,
  output logic       is_prefix,
  output logic [2:0] m_cycle,
  output logic       final_cycle,
  output logic       halted,
  output logic       instr_done
);
  seq_state_t state_q, state_d;
  logic [7:0] op_q, op_d, op_prefix_q, op_prefix_d;
  logic [2:0] m_cycle_q, m_cycle_d, last_main, last_cb, last;
  logic       instr_done_q, instr_done_d;
  m_cycle_num_table u_table (
    .op        (op_q),
    .op_prefix (op_prefix_q),
    .last_main (last_main),
    .last_cb   (last_cb)
  );
  // The CB prefix byte occupies a single M-cycle regardless of what the main table holds for it.
  always_comb begin
    last = state_q == S_CB ? last_cb : op_q == OP_PREFIX ? 3'd0 : last_main;
    final_cycle = state_q != S_HALT && (m_cycle_q == last || cut_short);
  end
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    op_prefix_d = op_prefix_q;
    m_cycle_d = m_cycle_q;
    instr_done_d = 1'b0;
    if (tick) begin
      if (state_q == S_HALT) begin
        if (irq_pending) begin
          op_d = rdata;
          state_d = S_EXEC;
        end
      end else if (!final_cycle) begin
        m_cycle_d = m_cycle_q + 3'd1;
      end else begin
        m_cycle_d = 3'd0;
        if (state_q == S_CB) begin
          op_d = rdata;
          state_d = S_EXEC;
          instr_done_d = 1'b1;
        end else if (op_q == OP_PREFIX) begin
          op_prefix_d = rdata;
          state_d = S_CB;
        end else if (op_q == OP_HALT) begin
          state_d = S_HALT;
          instr_done_d = 1'b1;
        end else begin
          op_d = rdata;
          instr_done_d = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_EXEC;
      op_q <= RESET_OP;
      op_prefix_q <= OP_NOP;
      m_cycle_q <= 3'd0;
      instr_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      op_prefix_q <= op_prefix_d;
      m_cycle_q <= m_cycle_d;
      instr_done_q <= instr_done_d;
    end
  end
  always_comb begin
    op = op_q;
    op_prefix = op_prefix_q;
    is_prefix = state_q == S_CB;
    m_cycle = m_cycle_q;
    halted = state_q == S_HALT;
    instr_done = instr_done_q;
  end
endmodule
